acc32_stream: RTL and testbench



---
 rtl/acc32_pkg.sv | 19 +
 rtl/sparse_32bitks.sv | 87 ++++++++
 rtl/acc32_stream.sv | 138 +++++++++++++
 tb/tb_acc32_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc32_pkg
// Description : Shared types and constants for the acc32_stream reduction engine.
// Revision    : 1.0 - initial release
// ============================================================================
package acc32_pkg;

    localparam int          c_word_w  = 32;
    localparam logic [31:0] c_sat_val = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sparse_32bitks.sv
`default_nettype none
// ============================================================================
// Module      : sparse_32bitks
// Description : 32-bit sparse Kogge-Stone adder (prefix tree every 4 bits,
//               ripple inside each nibble), no carry-in.
// Revision    : 1.0 - initial release
// ============================================================================
module sparse_32bitks
    import acc32_pkg::*;
(
    input  logic [c_word_w-1:0] a,
    input  logic [c_word_w-1:0] b,
    output logic [c_word_w-1:0] sum,
    output logic                cout
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [7:0]  w_g0, w_g1, w_g2, w_g3;
    logic [7:1]  w_p0;
    logic [7:2]  w_p1;
    logic [7:4]  w_p2;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Nibble-level generate/propagate; nibble 0 never needs P since cin is 0.
    for (genvar k = 0; k < 8; k++) begin : g_blk
        localparam int B = 4 * k;
        assign w_g0[k] = w_g[B+3]
                       | (w_p[B+3] & w_g[B+2])
                       | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                       | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
        if (k > 0) begin : g_p
            assign w_p0[k] = &w_p[B+3:B];
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_lvl1
        if (i == 0) begin : g_pass
            assign w_g1[i] = w_g0[i];
        end else begin : g_op
            assign w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
            if (i >= 2) begin : g_p
                assign w_p1[i] = w_p0[i] & w_p0[i-1];
            end
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_lvl2
        if (i < 2) begin : g_pass
            assign w_g2[i] = w_g1[i];
        end else begin : g_op
            assign w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
            if (i >= 4) begin : g_p
                assign w_p2[i] = w_p1[i] & w_p1[i-2];
            end
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_lvl3
        if (i < 4) begin : g_pass
            assign w_g3[i] = w_g2[i];
        end else begin : g_op
            assign w_g3[i] = w_g2[i] | (w_p2[i] & w_g2[i-4]);
        end
    end

    // Per-nibble ripple from the prefix carry into that nibble.
    for (genvar k = 0; k < 8; k++) begin : g_sum
        localparam int B = 4 * k;
        logic w_cb, w_c1, w_c2, w_c3;
        if (k == 0) begin : g_c0
            assign w_cb = 1'b0;
        end else begin : g_cn
            assign w_cb = w_g3[k-1];
        end
        assign w_c1 = w_g[B]   | (w_p[B]   & w_cb);
        assign w_c2 = w_g[B+1] | (w_p[B+1] & w_c1);
        assign w_c3 = w_g[B+2] | (w_p[B+2] & w_c2);
        assign sum[B+3:B] = w_p[B+3:B] ^ {w_c3, w_c2, w_c1, w_cb};
    end

    assign cout = w_g3[7];

endmodule
`default_nettype wire

// File: rtl/acc32_stream.sv
`default_nettype none
// ============================================================================
// Module      : acc32_stream
// Description : Streaming frame accumulator; sums BLOCK_LEN words through the
//               sparse KS adder. Define ACC_SAT_EN for saturating mode.
// Revision    : 1.0 - initial release
// ============================================================================
module acc32_stream
    import acc32_pkg::*;
#(
    parameter int BLOCK_LEN = 8,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [c_word_w-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [c_word_w-1:0] out_sum,
    output logic [CNT_W-1:0]    out_carries,
    output logic                out_sat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(BLOCK_LEN - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [c_word_w-1:0] r_acc;
    logic [CNT_W-1:0]    r_carries;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_word_w-1:0] w_sum;
    logic                w_cout;
    logic                w_in_hs;
    logic                w_out_hs;
    logic                w_clear;

    sparse_32bitks u_add (
        .a    (r_acc),
        .b    (in_data),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_in_hs  = in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & out_ready;
    assign w_clear  = (r_state == IDLE) & start;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = ACC;
            ACC:     if (w_in_hs && (r_cnt == c_last)) w_state_nxt = OUT;
            OUT:     if (w_out_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they leave flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ACC);
            r_out_valid <= (w_state_nxt == OUT);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
        end else if (w_in_hs) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef ACC_SAT_EN
    logic r_sat;

    // Once saturated the total is pinned at all-ones for the rest of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_carries <= '0;
            r_sat     <= 1'b0;
        end else if (w_clear) begin
            r_acc     <= '0;
            r_carries <= '0;
            r_sat     <= 1'b0;
        end else if (w_in_hs) begin
            if (w_cout || r_sat) begin
                r_acc <= c_sat_val;
                r_sat <= 1'b1;
            end else begin
                r_acc <= w_sum;
            end
        end
    end

    assign out_sat = r_sat;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_carries <= '0;
        end else if (w_clear) begin
            r_acc     <= '0;
            r_carries <= '0;
        end else if (w_in_hs) begin
            r_acc     <= w_sum;
            r_carries <= r_carries + {{(CNT_W-1){1'b0}}, w_cout};
        end
    end

    assign out_sat = 1'b0;
`endif

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign out_sum     = r_acc;
    assign out_carries = r_carries;

endmodule
`default_nettype wire

// File: tb/tb_acc32_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc32_stream
// Description : Directed self-checking bench for acc32_stream (BLOCK_LEN 4/1/2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc32_stream;

    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        start_v;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              out_ready;
    logic [2:0]        in_ready_v;
    logic [2:0]        out_valid_v;
    logic [2:0]        busy_v;
    logic [2:0]        sat_v;
    logic [31:0]       sum_v [3];
    logic [CNT_W-1:0]  car_v [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    acc32_stream #(.BLOCK_LEN(4), .CNT_W(CNT_W)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_v[0]), .out_sum(sum_v[0]),
        .out_carries(car_v[0]), .out_sat(sat_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .busy(busy_v[0])
    );

    acc32_stream #(.BLOCK_LEN(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_v[1]), .out_sum(sum_v[1]),
        .out_carries(car_v[1]), .out_sat(sat_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .busy(busy_v[1])
    );

    acc32_stream #(.BLOCK_LEN(2), .CNT_W(CNT_W)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_v[2]), .out_sum(sum_v[2]),
        .out_carries(car_v[2]), .out_sat(sat_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .busy(busy_v[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int d);
        start_v[d] = 1'b1;
        cyc();
        start_v[d] = 1'b0;
    endtask

    task automatic feed(input int d, input logic [31:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready_v[d] && n < 20) begin
            cyc();
            n++;
        end
        if (!in_ready_v[d]) check("feed_timeout", 64'd0, 64'd1);
        else cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int d);
        int n = 0;
        while (!out_valid_v[d] && n < 20) begin
            cyc();
            n++;
        end
        if (!out_valid_v[d]) check("out_timeout", 64'd0, 64'd1);
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic check_zero(input string tag, input int d);
        check({tag, "_in_ready"},  64'(in_ready_v[d]),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid_v[d]), 64'd0);
        check({tag, "_busy"},      64'(busy_v[d]),      64'd0);
        check({tag, "_sum"},       64'(sum_v[d]),       64'd0);
        check({tag, "_carries"},   64'(car_v[d]),       64'd0);
        check({tag, "_sat"},       64'(sat_v[d]),       64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int gap;
        rst_n     = 1'b0;
        start_v   = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cyc(3);
        check_zero("rst", 0);
        rst_n = 1'b1;
        cyc();

        // Basic frame 1,2,3,4 on consecutive cycles.
        start_frame(0);
        check("t1_in_ready", 64'(in_ready_v[0]), 64'd1);
        check("t1_busy",     64'(busy_v[0]),     64'd1);
        feed(0, 32'd1);
        feed(0, 32'd2);
        feed(0, 32'd3);
        check("t1_early_valid", 64'(out_valid_v[0]), 64'd0);
        feed(0, 32'd4);
        check("t1_valid",    64'(out_valid_v[0]), 64'd1);
        check("t1_sum",      64'(sum_v[0]),       64'd10);
        check("t1_carries",  64'(car_v[0]),       64'd0);
        check("t1_sat",      64'(sat_v[0]),       64'd0);
        check("t1_out_rdy",  64'(in_ready_v[0]),  64'd0);
        take_out();
        check("t1_idle_busy",  64'(busy_v[0]),      64'd0);
        check("t1_idle_valid", 64'(out_valid_v[0]), 64'd0);

        // Four all-ones words.
        start_frame(0);
        repeat (4) feed(0, 32'hFFFF_FFFF);
        wait_out(0);
`ifdef ACC_SAT_EN
        check("t2_sum",     64'(sum_v[0]), 64'hFFFF_FFFF);
        check("t2_carries", 64'(car_v[0]), 64'd0);
        check("t2_sat",     64'(sat_v[0]), 64'd1);
`else
        check("t2_sum",     64'(sum_v[0]), 64'hFFFF_FFFC);
        check("t2_carries", 64'(car_v[0]), 64'd3);
        check("t2_sat",     64'(sat_v[0]), 64'd0);
`endif
        take_out();

        // Gaps with junk data and start pulses during ACC, backpressure in OUT.
        start_frame(0);
        for (int i = 0; i < 4; i++) begin
            feed(0, 32'(100 * (i + 1)));
            if (i < 3) begin
                gap = $urandom_range(1, 3);
                in_data = 32'hDEAD_BEEF;
                for (int g = 0; g < gap; g++) begin
                    start_v[0] = (g == 0);
                    cyc();
                end
                start_v[0] = 1'b0;
            end
        end
        wait_out(0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            start_v[0] = 1'b1;
            cyc();
            check("t3_hold_sum",   64'(sum_v[0]),       64'd1000);
            check("t3_hold_ready", 64'(in_ready_v[0]),  64'd0);
            check("t3_hold_valid", 64'(out_valid_v[0]), 64'd1);
        end
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        out_ready  = 1'b0;
        check("t3_hs_busy",  64'(busy_v[0]),     64'd0);
        check("t3_hs_ready", 64'(in_ready_v[0]), 64'd0);
        cyc();
        check("t3_after_busy", 64'(busy_v[0]), 64'd0);

        // Asynchronous reset after two accepted words.
        start_frame(0);
        feed(0, 32'd7);
        feed(0, 32'd9);
        rst_n = 1'b0;
        #2;
        check_zero("t4_rst", 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        start_frame(0);
        repeat (4) feed(0, 32'd5);
        wait_out(0);
        check("t4_sum", 64'(sum_v[0]), 64'd20);
        take_out();

        // BLOCK_LEN = 1 back-to-back frames.
        start_frame(1);
        feed(1, 32'h1234_5678);
        check("t5_valid", 64'(out_valid_v[1]), 64'd1);
        check("t5_sum",   64'(sum_v[1]),       64'h1234_5678);
        take_out();
        check("t5_idle", 64'(busy_v[1]), 64'd0);
        start_frame(1);
        check("t5_restart_ready", 64'(in_ready_v[1]), 64'd1);
        check("t5_restart_sum",   64'(sum_v[1]),      64'd0);
        feed(1, 32'h0000_0011);
        check("t5_valid2", 64'(out_valid_v[1]), 64'd1);
        check("t5_sum2",   64'(sum_v[1]),       64'h11);
        take_out();

        // Carry boundary with BLOCK_LEN = 2.
        start_frame(2);
        feed(2, 32'h8000_0000);
        feed(2, 32'h8000_0000);
        check("t6_valid", 64'(out_valid_v[2]), 64'd1);
`ifdef ACC_SAT_EN
        check("t6_sum",     64'(sum_v[2]), 64'hFFFF_FFFF);
        check("t6_carries", 64'(car_v[2]), 64'd0);
        check("t6_sat",     64'(sat_v[2]), 64'd1);
`else
        check("t6_sum",     64'(sum_v[2]), 64'd0);
        check("t6_carries", 64'(car_v[2]), 64'd1);
        check("t6_sat",     64'(sat_v[2]), 64'd0);
`endif
        take_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
